// File: rtl/ee_rc_node_solver.sv
// Forward-Euler solver for a single RC node driven by a Thevenin source,
// a grounded resistor and a grounded capacitor, with a settling detector.
module ee_rc_node_solver #(
    parameter int unsigned       VW         = 24,
    parameter int unsigned       FRAC       = 16,
    parameter int unsigned       KW         = 16,
    parameter logic signed [VW-1:0] V_INIT  = '0,
    parameter int unsigned       SETTLE_TOL = 16,
    parameter int unsigned       SETTLE_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 init_load,
    input  logic signed [VW-1:0] init_v,
    input  logic signed [VW-1:0] vs,
    input  logic        [KW-1:0] ks,
    input  logic        [KW-1:0] kg,
    output logic signed [VW-1:0] v_node,
    output logic signed [VW+1:0] dv,
    output logic                 settled
);

    localparam int unsigned DW = VW + 2;
    localparam int unsigned SW = VW + 3;
    localparam int unsigned PW = VW + KW + 2;
    localparam int unsigned CW = $clog2(SETTLE_CNT + 1);

    localparam logic signed [SW-1:0] SAT_MAX = {{4{1'b0}}, {(VW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{4{1'b1}}, {(VW-1){1'b0}}};
    localparam logic signed [DW-1:0] TOL_P   = DW'(SETTLE_TOL);
    localparam logic signed [DW-1:0] TOL_N   = -TOL_P;
    localparam logic        [CW-1:0] CNT_MAX = CW'(SETTLE_CNT);

    // Voltage words must keep at least a sign bit above the binary point.
    if (FRAC >= VW) begin : g_bad_frac
        $error("FRAC must be smaller than VW");
    end

    logic signed [VW-1:0] v_q, v_d;
    logic signed [DW-1:0] dv_q, dv_d;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic                 settled_q, settled_d;

    logic signed [VW:0]   diff;
    logic signed [KW:0]   ks_s, kg_s;
    logic signed [DW-1:0] t1, t2, step;
    logic signed [SW-1:0] sum;

    // Coupling terms; the wide product is floor-shifted back into volts.
    always_comb begin
        diff = (VW+1)'(vs) - (VW+1)'(v_q);
        ks_s = {1'b0, ks};
        kg_s = {1'b0, kg};
        t1   = DW'((PW'(diff) * PW'(ks_s)) >>> KW);
        t2   = DW'((PW'(v_q) * PW'(kg_s)) >>> KW);
        step = t1 - t2;
        sum  = SW'(v_q) + SW'(step);
    end

    // Next-state: init_load beats en; disabled cycles hold everything.
    always_comb begin
        v_d       = v_q;
        dv_d      = dv_q;
        cnt_d     = cnt_q;
        settled_d = settled_q;
        if (init_load) begin
            v_d       = init_v;
            dv_d      = '0;
            cnt_d     = '0;
            settled_d = 1'b0;
        end else if (en) begin
            dv_d = step;
            if (sum > SAT_MAX) begin
                v_d = VW'(SAT_MAX);
            end else if (sum < SAT_MIN) begin
                v_d = VW'(SAT_MIN);
            end else begin
                v_d = VW'(sum);
            end
            if (step <= TOL_P && step >= TOL_N) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
            end
            settled_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= V_INIT;
            dv_q      <= '0;
            cnt_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            v_q       <= v_d;
            dv_q      <= dv_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    assign v_node  = v_q;
    assign dv      = dv_q;
    assign settled = settled_q;

endmodule

// File: tb/tb_ee_rc_node_solver.sv
// Directed and randomized checks of ee_rc_node_solver against an integer
// reference model of the forward-Euler node equation.
module tb_ee_rc_node_solver;

    localparam int VW = 24;
    localparam int KW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 init_load = 1'b0;
    logic signed [VW-1:0] init_v = '0;
    logic signed [VW-1:0] vs = '0;
    logic        [KW-1:0] ks = '0;
    logic        [KW-1:0] kg = '0;
    logic signed [VW-1:0] v_node;
    logic signed [VW+1:0] dv;
    logic                 settled;

    int checks = 0;
    int errors = 0;

    longint m_v = 0;
    longint m_dv = 0;
    int     m_cnt = 0;
    bit     m_set = 1'b0;

    ee_rc_node_solver dut (
        .clk(clk), .rst_n(rst_n), .en(en), .init_load(init_load),
        .init_v(init_v), .vs(vs), .ks(ks), .kg(kg),
        .v_node(v_node), .dv(dv), .settled(settled)
    );

    always #5 clk = ~clk;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: one physical Euler step from the current inputs.
    function automatic void model_step();
        longint st, nv;
        if (init_load) begin
            m_v = longint'(init_v); m_dv = 0; m_cnt = 0; m_set = 1'b0;
        end else if (en) begin
            st = floor_div((longint'(vs) - m_v) * longint'(ks), 65536)
               - floor_div(m_v * longint'(kg), 65536);
            nv = m_v + st;
            if (nv > 8388607) nv = 8388607;
            if (nv < -8388608) nv = -8388608;
            m_v  = nv;
            m_dv = st;
            if (st <= 16 && st >= -16) m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
            else m_cnt = 0;
            m_set = (m_cnt == 8);
        end
    endfunction

    function automatic void model_reset();
        m_v = 0; m_dv = 0; m_cnt = 0; m_set = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".v"}, 64'(v_node), 64'(m_v));
        chk({tag, ".dv"}, 64'(dv), 64'(m_dv));
        chk({tag, ".settled"}, 64'(settled), 64'(m_set));
    endtask

    task automatic cyc(input string tag);
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        longint chg_exp [4];
        chg_exp[0] = 163840; chg_exp[1] = 245760;
        chg_exp[2] = 286720; chg_exp[3] = 307200;

        // Reset state, then hold with en low.
        #12;
        model_reset();
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc("hold_en0");

        // Pure RC charge toward 5 V.
        vs = 24'sd327680; ks = 16'h8000; kg = '0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc("charge");
            chk("charge_seq", 64'(v_node), 64'(chg_exp[i]));
        end
        for (int i = 0; i < 100 && !m_set; i++) cyc("charge_tail");
        chk("charge_settled", 64'(settled), 64'd1);
        chk("charge_final_band",
            64'((v_node <= 24'sd327680) && (v_node >= 24'sd327648)), 64'd1);

        // Divider from 0 V.
        init_load = 1'b1; init_v = '0;
        cyc("div_init");
        init_load = 1'b0; ks = 16'h4000; kg = 16'h4000;
        cyc("div_first");
        chk("div_first_v", 64'(v_node), 64'd81920);
        chk("div_first_dv", 64'(dv), 64'd81920);
        for (int i = 0; i < 200 && !m_set; i++) cyc("div_run");
        chk("div_settled", 64'(settled), 64'd1);
        chk("div_final_band",
            64'((v_node <= 24'sd163856) && (v_node >= 24'sd163824)), 64'd1);

        // init_load wins over en during charging.
        kg = '0; ks = 16'h8000; vs = 24'sd327680;
        cyc("pre_load"); cyc("pre_load");
        init_load = 1'b1; init_v = -24'sd65536;
        cyc("init_prio");
        chk("init_prio_v", 64'(v_node), -64'sd65536);
        chk("init_prio_dv", 64'(dv), 64'd0);
        chk("init_prio_settled", 64'(settled), 64'd0);
        init_load = 1'b0; vs = '0;
        cyc("after_load");
        chk("after_load_v", 64'(v_node), -64'sd32768);

        // Saturation at both rails.
        init_load = 1'b1; init_v = 24'sd8388607;
        cyc("sat_init");
        init_load = 1'b0; vs = 24'sd8388607; ks = 16'hFFFF; kg = '0;
        cyc("sat_hi");
        chk("sat_hi_v", 64'(v_node), 64'sd8388607);
        vs = -24'sd8388608; kg = 16'hFFFF;
        cyc("sat_lo");
        chk("sat_lo_v", 64'(v_node), -64'sd8388608);

        // Asynchronous reset between edges.
        init_load = 1'b1; init_v = '0;
        cyc("ar_init");
        init_load = 1'b0; vs = 24'sd327680; ks = 16'h8000; kg = '0;
        cyc("ar_step"); cyc("ar_step");
        chk("ar_pre_v", 64'(v_node), 64'sd245760);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("ar_async");
        #1;
        rst_n = 1'b1;
        cyc("ar_resume");
        chk("ar_resume_v", 64'(v_node), 64'sd163840);

        // Randomized operation with slowly changing operating points.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            init_load = ($urandom_range(0, 39) == 0);
            init_v    = VW'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                vs = VW'($urandom);
                ks = KW'($urandom_range(0, 65535));
                if ($urandom_range(0, 7) == 0) kg = KW'($urandom);
                else kg = KW'($urandom_range(0, 65535 - int'(ks)));
            end
            cyc("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
